vec_group_addr_seq: RTL and testbench
=====================================

// Module: vec_group_addr_seq
// PURPOSE
//  Multi-port successor to the single-operand register-group address generator. Accepts one vector
//  command (NUM_PORTS base registers + vlmul + per-port widen flags) and walks the register group.
//  Each beat is one (register, offset) step and emits one address/offset pair per port.
//  Sits between the vector decode/issue stage and the VRF read/write ports; adds ready/valid backpressure,
//  per-port widening (EMUL=2*LMUL) and abort.
// PARAMETERS
//  ADDR_WIDTH  5  VRF register index width (32 vector registers)
//  OFF_WIDTH   8  intra-register beat offset width
//  NUM_PORTS   3  operand channels (e.g. vs1, vs2, vd)
// PORTS
//  clk        in   1                     clock
//  rst_n      in   1                     async active-low reset
//  in_valid   in   1                     command valid
//  in_ready   out  1                     command accepted when in_valid&in_ready
//  vlmul      in   3                     RVV vlmul encoding
//  max_off_in in   OFF_WIDTH             last beat offset per register (LMUL=1); power of two minus 1
//  addr_in    in   NUM_PORTS*ADDR_WIDTH  per-port base register (port p at [p*ADDR_WIDTH +: ADDR_WIDTH])
//  widen_in   in   NUM_PORTS             per-port widening flag
//  abort      in   1                     flush current sequence
//  out_valid  out  1                     beat valid
//  out_ready  in   1                     beat consumed when out_valid&out_ready
//  addr_out   out  NUM_PORTS*ADDR_WIDTH  per-port VRF register index
//  off_out    out  NUM_PORTS*OFF_WIDTH   per-port beat offset
//  addr_start out  1                     qualifies first beat of command
//  addr_end   out  1                     qualifies last beat of command
//  cfg_err    out  1                     1-cycle pulse: reserved vlmul=3'b100 accepted
//  idle       out  1                     state==IDLE and no pending beat
// BEHAVIOUR
//  - Reset (async): state=IDLE; out_valid=0; in_ready=1; idle=1; cfg_err=0.
//    addr_out, off_out, addr_start and addr_end are 0. All counters are 0.
//  - FSM IDLE/BUSY. IDLE->BUSY on accept. BUSY->IDLE on last-beat handshake with no new accept, or on abort.
//  - in_ready = ~abort & (IDLE | (out_valid & out_ready & addr_end)). This gives back-to-back commands with no bubble.
//  - Latency: command accepted in cycle N -> first beat has out_valid=1 in cycle N+1. All outputs are registered.
//  - Beat limits (latched at accept):
//      vlmul 000/001/010/011 -> max_reg = 0/1/3/7; max_off = max_off_in
//      vlmul 101/110/111     -> max_reg = 0;       max_off = max_off_in>>3 / >>2 / >>1
//      vlmul 100 (reserved)  -> treated as 000; cfg_err pulses in cycle N+1
//  - Iteration: off_cnt increments each handshake. When off_cnt==max_off, off_cnt wraps to 0 and reg_cnt increments.
//    The last beat is reg_cnt==max_reg & off_cnt==max_off.
//  - Port p, narrow: addr = base_p + reg_cnt; off = off_cnt.
//  - Port p, widened: addr = base_p + 2*reg_cnt + hi, where hi = off_cnt > (max_off>>1);
//    off = (off_cnt<<1) & max_off. Widening with max_off=0 gives hi=0 and off=0.
//  - Address arithmetic wraps modulo 2^ADDR_WIDTH; no error is flagged.
//  - Backpressure: out_valid & ~out_ready holds every output and counter stable.
//  - addr_start=1 only on beat 0. addr_end=1 only on the last beat. Both are 1 for a single-beat command.
//  - abort: synchronous, highest priority. Next cycle out_valid=0 and state=IDLE.
//    in_ready=0 in the abort cycle, so a coincident in_valid is not accepted.
//  - rst_n low mid-sequence: immediate return to reset values; no partial beat is emitted after release.
//  - idle = IDLE & ~out_valid.
// STRUCTURE
//  - Package vec_agu_pkg: vlmul encoding localparams (LMUL1, LMUL2, LMUL4, LMUL8, MF8, MF4, MF2, RSVD).
//    It also holds function max_reg_of(vlmul), function frac_shift(vlmul), and typedef agu_state_e {IDLE, BUSY}.
//  - Sub-module vec_agu_port_map: combinational base/reg_cnt/off_cnt/widen -> addr/off.
//    It is generated NUM_PORTS times. The top holds the FSM, counters and output registers.
// TESTING
//  1. vlmul=010, max_off_in=3, bases 4/8/12, no widen, out_ready=1.
//     -> 16 beats; port0 addr runs 4,4,4,4,5..7, off cycles 0..3; addr_start on beat 0; addr_end on beat 15.
//  2. vlmul=111, max_off_in=7 -> max_off=3; 4 beats, addr=base on every beat; vlmul=101 -> exactly 1 beat.
//  3. vlmul=001, max_off_in=3, port2 widen, base 16.
//     -> port2 addr 16,16,17,17,18,18,19,19 with off 0,2,0,2 repeating; ports 0/1 unchanged.
//  4. out_ready toggled 1-0-0-1 during case 1 -> outputs frozen while low; same 16-beat sequence; no beat dropped or duplicated.
//  5. Second command with in_valid held during the last beat -> accepted on that handshake; its beat 0 follows next cycle, no gap.
//     abort on beat 5 -> out_valid=0 next cycle, idle=1.
//  6. vlmul=100 -> 4 beats (max_off_in=3) and one cfg_err pulse.
//     Base 30 with vlmul=010 -> addr 30,31,0,1 (wrap).
//     rst_n asserted mid-sequence -> all outputs 0 and in_ready=1 at once.

Source files
------------

// File: rtl/vec_agu_pkg.sv
// vec_agu_pkg: vlmul encodings, per-vlmul beat-limit helpers and FSM state type
// shared by the vector register-group address sequencer.
package vec_agu_pkg;

    localparam logic [2:0] LMUL1 = 3'b000;
    localparam logic [2:0] LMUL2 = 3'b001;
    localparam logic [2:0] LMUL4 = 3'b010;
    localparam logic [2:0] LMUL8 = 3'b011;
    localparam logic [2:0] RSVD  = 3'b100;
    localparam logic [2:0] MF8   = 3'b101;
    localparam logic [2:0] MF4   = 3'b110;
    localparam logic [2:0] MF2   = 3'b111;

    typedef enum logic {IDLE, BUSY} agu_state_e;

    // Last register index within the group; fractional and reserved encodings use one register.
    function automatic logic [2:0] max_reg_of(input logic [2:0] vlmul);
        return vlmul == LMUL1 ? 3'd0 :
               vlmul == LMUL2 ? 3'd1 :
               vlmul == LMUL4 ? 3'd3 :
               vlmul == LMUL8 ? 3'd7 : 3'd0;
    endfunction

    function automatic logic [1:0] frac_shift(input logic [2:0] vlmul);
        return vlmul == MF8 ? 2'd3 :
               vlmul == MF4 ? 2'd2 :
               vlmul == MF2 ? 2'd1 : 2'd0;
    endfunction

endpackage

// File: rtl/vec_agu_port_map.sv
// vec_agu_port_map: maps the shared group position to one port's VRF register
// index and beat offset, doubling the register stride for widened operands.
module vec_agu_port_map
    import vec_agu_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int OFF_WIDTH  = 8
) (
    input  logic [ADDR_WIDTH-1:0] base,
    input  logic [2:0]            reg_cnt,
    input  logic [OFF_WIDTH-1:0]  off_cnt,
    input  logic [OFF_WIDTH-1:0]  max_off,
    input  logic                  widen,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [OFF_WIDTH-1:0]  off
);

    logic hi;

    // A widened operand spans two registers per narrow register: the upper half
    // of the narrow offset range lands in the odd register of the pair.
    assign hi   = widen & (off_cnt > (max_off >> 1));
    assign addr = base + (widen ? ADDR_WIDTH'({reg_cnt, 1'b0}) : ADDR_WIDTH'(reg_cnt)) + ADDR_WIDTH'(hi);
    assign off  = widen ? ((off_cnt << 1) & max_off) : off_cnt;

endmodule

// File: rtl/vec_group_addr_seq.sv
// vec_group_addr_seq: walks a vector register group for NUM_PORTS operands,
// emitting one registered address/offset beat per handshake with backpressure and abort.
module vec_group_addr_seq
    import vec_agu_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int OFF_WIDTH  = 8,
    parameter int NUM_PORTS  = 3
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [2:0]                      vlmul,
    input  logic [OFF_WIDTH-1:0]            max_off_in,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr_in,
    input  logic [NUM_PORTS-1:0]            widen_in,
    input  logic                            abort,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [NUM_PORTS*ADDR_WIDTH-1:0] addr_out,
    output logic [NUM_PORTS*OFF_WIDTH-1:0]  off_out,
    output logic                            addr_start,
    output logic                            addr_end,
    output logic                            cfg_err,
    output logic                            idle
);

    agu_state_e                      state, nxt_state;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] base_q, nxt_base;
    logic [NUM_PORTS-1:0]            widen_q, nxt_widen;
    logic [2:0]                      max_reg_q, nxt_max_reg;
    logic [OFF_WIDTH-1:0]            max_off_q, nxt_max_off;
    logic [2:0]                      reg_q, nxt_reg;
    logic [OFF_WIDTH-1:0]            off_q, nxt_off;
    logic                            nxt_valid, nxt_start, nxt_end, nxt_cfg_err;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] map_addr;
    logic [NUM_PORTS*OFF_WIDTH-1:0]  map_off;
    logic                            accept, fire, wrap;

    // Accepting during the last-beat handshake lets commands run back to back.
    assign in_ready = ~abort & ((state == IDLE) | (out_valid & out_ready & addr_end));
    assign accept   = in_valid & in_ready;
    assign fire     = out_valid & out_ready;
    assign wrap     = off_q == max_off_q;
    assign idle     = (state == IDLE) & ~out_valid;

    always_comb begin
        nxt_state   = state;
        nxt_valid   = out_valid;
        nxt_start   = addr_start;
        nxt_end     = addr_end;
        nxt_cfg_err = 1'b0;
        nxt_base    = base_q;
        nxt_widen   = widen_q;
        nxt_max_reg = max_reg_q;
        nxt_max_off = max_off_q;
        nxt_reg     = reg_q;
        nxt_off     = off_q;
        if (abort) begin
            nxt_state = IDLE;
            nxt_valid = 1'b0;
            nxt_start = 1'b0;
            nxt_end   = 1'b0;
        end else if (accept) begin
            nxt_state   = BUSY;
            nxt_valid   = 1'b1;
            nxt_base    = addr_in;
            nxt_widen   = widen_in;
            nxt_max_reg = max_reg_of(vlmul);
            nxt_max_off = max_off_in >> frac_shift(vlmul);
            nxt_reg     = '0;
            nxt_off     = '0;
            nxt_start   = 1'b1;
            nxt_end     = (nxt_max_reg == '0) && (nxt_max_off == '0);
            nxt_cfg_err = vlmul == RSVD;
        end else if (fire && addr_end) begin
            nxt_state = IDLE;
            nxt_valid = 1'b0;
            nxt_start = 1'b0;
            nxt_end   = 1'b0;
        end else if (fire) begin
            nxt_off   = wrap ? '0 : off_q + 1'b1;
            nxt_reg   = wrap ? reg_q + 3'd1 : reg_q;
            nxt_start = 1'b0;
            nxt_end   = (nxt_reg == max_reg_q) && (nxt_off == max_off_q);
        end
    end

    // Map the next position so every beat output comes straight from a flop.
    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
        vec_agu_port_map #(
            .ADDR_WIDTH(ADDR_WIDTH),
            .OFF_WIDTH (OFF_WIDTH)
        ) u_map (
            .base   (nxt_base[g*ADDR_WIDTH +: ADDR_WIDTH]),
            .reg_cnt(nxt_reg),
            .off_cnt(nxt_off),
            .max_off(nxt_max_off),
            .widen  (nxt_widen[g]),
            .addr   (map_addr[g*ADDR_WIDTH +: ADDR_WIDTH]),
            .off    (map_off[g*OFF_WIDTH +: OFF_WIDTH])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            out_valid  <= 1'b0;
            addr_start <= 1'b0;
            addr_end   <= 1'b0;
            cfg_err    <= 1'b0;
            addr_out   <= '0;
            off_out    <= '0;
            base_q     <= '0;
            widen_q    <= '0;
            max_reg_q  <= '0;
            max_off_q  <= '0;
            reg_q      <= '0;
            off_q      <= '0;
        end else begin
            state      <= nxt_state;
            out_valid  <= nxt_valid;
            addr_start <= nxt_start;
            addr_end   <= nxt_end;
            cfg_err    <= nxt_cfg_err;
            addr_out   <= map_addr;
            off_out    <= map_off;
            base_q     <= nxt_base;
            widen_q    <= nxt_widen;
            max_reg_q  <= nxt_max_reg;
            max_off_q  <= nxt_max_off;
            reg_q      <= nxt_reg;
            off_q      <= nxt_off;
        end
    end

endmodule

// File: tb/tb_vec_group_addr_seq.sv
// tb_vec_group_addr_seq: scenario tasks compare observed beats against a
// beat-index arithmetic model of the register-group walk.
module tb_vec_group_addr_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [2:0]  vlmul;
    logic [7:0]  max_off_in;
    logic [14:0] addr_in;
    logic [2:0]  widen_in;
    logic        abort;
    logic        out_valid, out_ready;
    logic [14:0] addr_out;
    logic [23:0] off_out;
    logic        addr_start, addr_end, cfg_err, idle;

    int total = 0;
    int bad = 0;
    int err_cnt;
    logic [40:0] exp_q[$];
    logic [40:0] obs_q[$];

    vec_group_addr_seq dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .vlmul(vlmul), .max_off_in(max_off_in), .addr_in(addr_in), .widen_in(widen_in),
        .abort(abort), .out_valid(out_valid), .out_ready(out_ready),
        .addr_out(addr_out), .off_out(off_out), .addr_start(addr_start),
        .addr_end(addr_end), .cfg_err(cfg_err), .idle(idle)
    );

    always #5 clk = ~clk;

    // Beat i sits at register i/(mo+1), offset i%(mo+1) of the group.
    function automatic void build_exp(input logic [2:0] vl, input int moi, input logic [14:0] b, input logic [2:0] w);
        int regs, mo, n, r, o, a, of;
        logic [14:0] av;
        logic [23:0] ov;
        exp_q.delete();
        regs = (vl <= 3) ? (1 << vl) : 1;
        mo = (vl >= 5) ? (moi >> (8 - vl)) : moi;
        n = regs * (mo + 1);
        for (int i = 0; i < n; i++) begin
            r = i / (mo + 1);
            o = i % (mo + 1);
            for (int p = 0; p < 3; p++) begin
                a  = w[p] ? int'(b[p*5 +: 5]) + 2 * r + ((o > mo / 2) ? 1 : 0) : int'(b[p*5 +: 5]) + r;
                of = w[p] ? (2 * o) % (mo + 1) : o;
                a  = a % 32;
                av[p*5 +: 5] = a[4:0];
                ov[p*8 +: 8] = of[7:0];
            end
            exp_q.push_back({i == 0, i == n - 1, av, ov});
        end
    endfunction

    task automatic send(input logic [2:0] vl, input logic [7:0] moi, input logic [14:0] b, input logic [2:0] w);
        vlmul = vl; max_off_in = moi; addr_in = b; widen_in = w; in_valid = 1'b1;
        for (int k = 0; k < 50 && !in_ready; k++) @(negedge clk);
        if (!in_ready) begin
            total++; bad++;
            $display("FAIL send: in_ready=%b required 1 within 50 cycles", in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic collect(input bit stall);
        bit done = 0;
        obs_q.delete();
        err_cnt = 0;
        for (int c = 0; c < 2000 && !done; c++) begin
            out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (cfg_err) err_cnt++;
            if (out_valid && out_ready) begin
                obs_q.push_back({addr_start, addr_end, addr_out, off_out});
                done = addr_end;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        total++;
        if ({out_valid, in_ready, idle, cfg_err, addr_start, addr_end} !== 6'b011000) begin
            bad++;
            $display("FAIL reset_flags: got v/rdy/idle/err/s/e=%b required 011000",
                     {out_valid, in_ready, idle, cfg_err, addr_start, addr_end});
        end
        total++;
        if ({addr_out, off_out} !== 39'd0) begin
            bad++;
            $display("FAIL reset_data: got addr=%h off=%h required 0", addr_out, off_out);
        end
    endtask

    task automatic test_lmul4;
        send(3'b010, 8'd3, {5'd12, 5'd8, 5'd4}, 3'b000);
        build_exp(3'b010, 3, {5'd12, 5'd8, 5'd4}, 3'b000);
        collect(0);
        total++;
        if (obs_q.size() != exp_q.size()) begin
            bad++; $display("FAIL lmul4_count: got %0d required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL lmul4 beat %0d: got %h required %h", i, obs_q[i], exp_q[i]);
            end
        end
        total++;
        if (err_cnt != 0 || out_valid !== 1'b0 || idle !== 1'b1) begin
            bad++; $display("FAIL lmul4_end: got err=%0d valid=%b idle=%b required 0/0/1", err_cnt, out_valid, idle);
        end
    endtask

    task automatic test_frac;
        logic [2:0] vls [2] = '{3'b111, 3'b101};
        int nb [2] = '{4, 1};
        for (int t = 0; t < 2; t++) begin
            send(vls[t], 8'd7, {5'd3, 5'd2, 5'd1}, 3'b000);
            build_exp(vls[t], 7, {5'd3, 5'd2, 5'd1}, 3'b000);
            collect(0);
            total++;
            if (obs_q.size() != nb[t]) begin
                bad++; $display("FAIL frac_count vlmul=%b: got %0d required %0d", vls[t], obs_q.size(), nb[t]);
            end
            for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
                total++;
                if (obs_q[i] !== exp_q[i]) begin
                    bad++; $display("FAIL frac vlmul=%b beat %0d: got %h required %h", vls[t], i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_widen;
        send(3'b001, 8'd3, {5'd16, 5'd8, 5'd4}, 3'b100);
        build_exp(3'b001, 3, {5'd16, 5'd8, 5'd4}, 3'b100);
        collect(0);
        total++;
        if (obs_q.size() != 8) begin
            bad++; $display("FAIL widen_count: got %0d required 8", obs_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL widen beat %0d: got %h required %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_backpressure;
        logic [41:0] cur, snap;
        bit was_stall = 0;
        bit done = 0;
        send(3'b010, 8'd3, {5'd12, 5'd8, 5'd4}, 3'b000);
        build_exp(3'b010, 3, {5'd12, 5'd8, 5'd4}, 3'b000);
        obs_q.delete();
        snap = '0;
        for (int k = 0; k < 500 && !done; k++) begin
            out_ready = (k % 4 == 0) || (k % 4 == 3);
            cur = {out_valid, addr_start, addr_end, addr_out, off_out};
            if (was_stall) begin
                total++;
                if (cur !== snap) begin
                    bad++; $display("FAIL stall_hold cycle %0d: got %h required %h", k, cur, snap);
                end
            end
            was_stall = out_valid && !out_ready;
            snap = cur;
            if (out_valid && out_ready) begin
                obs_q.push_back(cur[40:0]);
                done = addr_end;
            end
            @(negedge clk);
        end
        total++;
        if (obs_q.size() != exp_q.size()) begin
            bad++; $display("FAIL stall_count: got %0d required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL stall beat %0d: got %h required %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        send(3'b000, 8'd3, {5'd1, 5'd2, 5'd3}, 3'b000);
        for (int c = 0; c < 50; c++) begin
            out_ready = 1'b1;
            if (out_valid && addr_end) break;
            @(negedge clk);
        end
        vlmul = 3'b001; max_off_in = 8'd1; addr_in = {5'd20, 5'd21, 5'd22}; widen_in = 3'b010; in_valid = 1'b1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL b2b_ready: got %b required 1", in_ready);
        end
        build_exp(3'b001, 1, {5'd20, 5'd21, 5'd22}, 3'b010);
        @(negedge clk);
        in_valid = 1'b0;
        total++;
        if ({out_valid, addr_start} !== 2'b11) begin
            bad++; $display("FAIL b2b_gap: got valid/start=%b required 11", {out_valid, addr_start});
        end
        collect(0);
        total++;
        if (obs_q.size() != exp_q.size()) begin
            bad++; $display("FAIL b2b_count: got %0d required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL b2b beat %0d: got %h required %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_abort;
        send(3'b010, 8'd3, {5'd12, 5'd8, 5'd4}, 3'b000);
        for (int k = 0; k < 5; k++) begin
            out_ready = 1'b1;
            @(negedge clk);
        end
        abort = 1'b1;
        in_valid = 1'b1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++; $display("FAIL abort_ready: got %b required 0", in_ready);
        end
        @(negedge clk);
        abort = 1'b0;
        in_valid = 1'b0;
        total++;
        if ({out_valid, idle} !== 2'b01) begin
            bad++; $display("FAIL abort_flush: got valid/idle=%b required 01", {out_valid, idle});
        end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL abort_noaccept: got valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_rsvd_wrap;
        send(3'b100, 8'd3, {5'd7, 5'd6, 5'd5}, 3'b000);
        build_exp(3'b100, 3, {5'd7, 5'd6, 5'd5}, 3'b000);
        collect(0);
        total++;
        if (obs_q.size() != 4 || err_cnt != 1) begin
            bad++; $display("FAIL rsvd: got beats=%0d cfg_err=%0d required 4/1", obs_q.size(), err_cnt);
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL rsvd beat %0d: got %h required %h", i, obs_q[i], exp_q[i]);
            end
        end
        send(3'b010, 8'd0, {5'd30, 5'd30, 5'd30}, 3'b000);
        build_exp(3'b010, 0, {5'd30, 5'd30, 5'd30}, 3'b000);
        collect(0);
        total++;
        if (obs_q.size() != 4) begin
            bad++; $display("FAIL wrap_count: got %0d required 4", obs_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL wrap beat %0d: got %h required %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random;
        logic [2:0]  vl;
        logic [7:0]  moi;
        logic [14:0] b;
        logic [2:0]  w;
        for (int t = 0; t < 12; t++) begin
            vl  = 3'($urandom_range(0, 7));
            moi = 8'((1 << $urandom_range(0, 4)) - 1);
            b   = 15'($urandom);
            w   = 3'($urandom);
            send(vl, moi, b, w);
            build_exp(vl, int'(moi), b, w);
            collect(1);
            total++;
            if (obs_q.size() != exp_q.size() || err_cnt != ((vl == 3'b100) ? 1 : 0)) begin
                bad++; $display("FAIL rand%0d_count: got beats=%0d err=%0d required %0d/%0d",
                                t, obs_q.size(), err_cnt, exp_q.size(), (vl == 3'b100) ? 1 : 0);
            end
            for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
                total++;
                if (obs_q[i] !== exp_q[i]) begin
                    bad++; $display("FAIL rand%0d beat %0d: got %h required %h", t, i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        bit saw = 0;
        send(3'b011, 8'd15, {5'd9, 5'd10, 5'd11}, 3'b001);
        for (int k = 0; k < 3; k++) begin
            out_ready = 1'b1;
            @(negedge clk);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({out_valid, in_ready, idle, addr_start, addr_end, addr_out, off_out} !== {5'b01100, 39'd0}) begin
            bad++; $display("FAIL reset_mid: got v/rdy/idle/s/e=%b addr=%h off=%h required 01100 and 0",
                            {out_valid, in_ready, idle, addr_start, addr_end}, addr_out, off_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            saw |= out_valid;
        end
        total++;
        if (saw) begin
            bad++; $display("FAIL reset_mid_release: got out_valid=1 required 0");
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; vlmul = '0; max_off_in = '0; addr_in = '0;
        widen_in = '0; abort = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        test_reset;
        rst_n = 1'b1;
        @(negedge clk);
        test_lmul4;
        test_frac;
        test_widen;
        test_backpressure;
        test_back_to_back;
        test_abort;
        test_rsvd_wrap;
        test_random;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
